uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: runtime baud divisor, configurable data bits, parity mode and stop bits.
//  3-sample majority vote at bit centre; false-start rejection; framing/parity error tagging per frame.
//  Received frames are buffered in a show-ahead FIFO with valid/ready handshake and a sticky overrun flag.
//  Sits between the board UART pin and the command/data path that consumes received bytes.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, sent LSB first
//  PARITY_MODE 0   0 = none, 1 = odd, 2 = even
//  STOP_BITS   1   1 or 2
//  FIFO_DEPTH  4   entries, power of 2, >= 2
//  DIV_WIDTH   16  width of baud_div
// PORTS
//  uart_clock     in   1                    system clock
//  uart_reset     in   1                    async active-low reset
//  uart_d_in      in   1                    serial line, idle high, asynchronous to uart_clock
//  baud_div       in   DIV_WIDTH            uart_clock cycles per bit, e.g. 868 = 115200 baud @ 100 MHz
//  rx_data        out  DATA_BITS            FIFO head data
//  rx_parity_err  out  1                    FIFO head parity error tag
//  rx_frame_err   out  1                    FIFO head framing error tag
//  rx_valid       out  1                    FIFO not empty
//  rx_ready       in   1                    consumer pop; a pop occurs when rx_valid & rx_ready
//  rx_overrun     out  1                    sticky: a frame was dropped because the FIFO was full
//  clear_err      in   1                    clears rx_overrun
//  rx_busy        out  1                    FSM not in IDLE
//  fifo_count     out  $clog2(FIFO_DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//  Clock and reset: clock uart_clock; reset uart_reset, asynchronous, active-low.
//  Reset: all outputs 0; FIFO empty; FSM in IDLE; synchroniser flops reset to 1 (idle line).
//   Reset mid-frame abandons the frame; nothing is pushed.
//  Input path: uart_d_in passes a 2-flop synchroniser (s). A start is a 1->0 transition of s seen in IDLE.
//  Divisor: baud_div is latched at start detect (div) and used for the whole frame.
//   A baud_div value < 4 is treated as 4. Half = div>>1.
//  Bit sampling: a counter resets at each bit boundary. The bit value is the majority of s at counts
//   half-1, half and half+1. The decision is taken at count half+1.
//  FSM states and transitions:
//   IDLE: on start detect, latch div, go to START.
//   START: at the start-bit decision; if majority = 1, false start, go to IDLE with no push and no flags.
//    Otherwise go to DATA.
//   DATA: one decision per bit, each div cycles apart, shifted in LSB first.
//    After DATA_BITS decisions, go to PARITY if PARITY_MODE != 0, else go to STOP.
//   PARITY: parity_err = (XOR of data bits ^ sampled bit) != (PARITY_MODE == 1).
//    That is, odd mode requires total ones to be odd. Then go to STOP.
//   STOP: each stop bit must sample 1; any 0 sets frame_err.
//    After STOP_BITS decisions, go to PUSH.
//   PUSH: one cycle. Write {parity_err, frame_err, data} to the FIFO, then go to IDLE.
//    A new start can be detected from the next cycle, which tolerates early starts by up to half a bit.
//  FIFO: show-ahead. rx_data, rx_parity_err and rx_frame_err are valid whenever rx_valid = 1.
//   An entry is visible on rx_valid the cycle after PUSH.
//   Pop and push in the same cycle: occupancy is unchanged, and this is legal even when full.
//   PUSH when full with no pop: the frame is discarded and rx_overrun is set on the next cycle.
//   Read/write pointers wrap modulo FIFO_DEPTH.
//  rx_overrun: clear_err clears it. If clear_err and a new overrun occur in the same cycle, set wins.
//  Errored frames are still pushed, with their tags; the consumer decides whether to discard them.
//  A line held low (break) gives frame_err with data = 0. The FSM then returns to IDLE and waits for a 1->0 transition.
// TESTING
//  8N1, baud_div=868, send 0xA5 -> rx_valid rises after about 9.5 bit times; rx_data=0xA5; both error tags 0; fifo_count=1.
//  PARITY_MODE=2, send 0x03 with parity bit 1 -> rx_parity_err=1. With parity bit 0 -> rx_parity_err=0.
//  Stop bit driven 0, send 0x55 -> rx_data=0x55, rx_frame_err=1; the next good frame is received clean.
//  3-cycle low glitch on an idle line, baud_div=868 -> no push, rx_busy returns to 0, fifo_count=0.
//  FIFO_DEPTH=4, rx_ready=0, send 0x11..0x55 -> fifo_count=4, rx_overrun=1.
//   Pops then return 0x11, 0x22, 0x33, 0x44; clear_err -> rx_overrun=0.
//  uart_reset asserted mid-DATA of 0x7E -> all outputs 0 and no push; the following 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with a runtime baud divisor and a show-ahead receive FIFO.
//   The serial input is synchronised, then a start edge launches a frame.
//   Each bit is the 3-sample majority around the bit centre. Every frame is
//   pushed with parity/framing error tags. A frame that arrives while the
//   FIFO is full is dropped, and the sticky overrun flag is set.
// Ports
//   uart_clock, uart_reset   system clock, async active-low reset
//   uart_d_in                serial line (idle high, asynchronous)
//   baud_div                 clock cycles per bit (values below 4 act as 4)
//   rx_data/_parity_err/_frame_err   FIFO head entry, valid with rx_valid
//   rx_valid, rx_ready       pop handshake
//   rx_overrun, clear_err    sticky drop flag and its clear
//   rx_busy                  receiver is inside a frame
//   fifo_count               FIFO occupancy
module uart_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                          uart_clock,
  input  logic                          uart_reset,
  input  logic                          uart_d_in,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          clear_err,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_PUSH   = 3'd5
  } state_t;

  // Two-of-three vote over the samples taken around the bit centre
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Odd mode needs an odd total count of ones, even mode an even count
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
    parity_fail = ((^d) ^ p) != (PARITY_MODE == 1);
  endfunction

  logic                 sync1_r, sync_r, prev_r;
  state_t               state_r;
  logic [DIV_WIDTH-1:0] div_r, cnt_r, half_s;
  logic [1:0]           samp_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r, frame_err_r, maj_s;

  logic [EW-1:0]        mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [AW:0]          count_r;
  logic                 overrun_r;
  logic                 push_s, pop_s, full_s, do_push_s, drop_s;

  assign half_s = div_r >> 1;
  // The third vote is the live sample at count half+1, the decision point
  assign maj_s  = maj3(samp_r[0], samp_r[1], sync_r);

  // Input synchroniser plus one delayed copy for start-edge detection
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      sync1_r <= 1'b1;
      sync_r  <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_d_in;
      sync_r  <= sync1_r;
      prev_r  <= sync_r;
    end
  end

  // Receive FSM: start detect, bit timing, majority sampling, frame assembly.
  // The bit counter free-runs modulo div for the whole frame, so every state
  // change happens at a decision point without disturbing bit alignment.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_r     <= ST_IDLE;
      div_r       <= '0;
      cnt_r       <= '0;
      samp_r      <= 2'b11;
      bit_cnt_r   <= 4'd0;
      shift_r     <= '0;
      par_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (prev_r && !sync_r) begin
            div_r       <= (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;
            cnt_r       <= DIV_WIDTH'(1);  // the detect cycle was count 0
            bit_cnt_r   <= 4'd0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            state_r     <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
          cnt_r <= (cnt_r == div_r - DIV_WIDTH'(1)) ? '0 : cnt_r + DIV_WIDTH'(1);
          if (cnt_r == half_s - DIV_WIDTH'(1)) samp_r[0] <= sync_r;
          if (cnt_r == half_s)                 samp_r[1] <= sync_r;
          if (cnt_r == half_s + DIV_WIDTH'(1)) begin
            case (state_r)
              ST_START: state_r <= maj_s ? ST_IDLE : ST_DATA;
              ST_DATA: begin
                shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
                if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                  bit_cnt_r <= 4'd0;
                  state_r   <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                end
              end
              ST_PARITY: begin
                par_err_r <= parity_fail(shift_r, maj_s);
                state_r   <= ST_STOP;
              end
              ST_STOP: begin
                if (!maj_s) frame_err_r <= 1'b1;
                if (bit_cnt_r == 4'(STOP_BITS - 1)) begin
                  state_r <= ST_PUSH;
                end else begin
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_PUSH: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign push_s    = (state_r == ST_PUSH);
  assign full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s     = rx_valid && rx_ready;
  // A simultaneous pop frees the head slot, so a push is accepted even when full
  assign do_push_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= {par_err_r, frame_err_r, shift_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overrun; a new drop beats a simultaneous clear
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (clear_err) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign rx_data       = mem_r[rd_ptr_r][DATA_BITS-1:0];
  assign rx_frame_err  = mem_r[rd_ptr_r][DATA_BITS];
  assign rx_parity_err = mem_r[rd_ptr_r][DATA_BITS+1];
  assign rx_valid      = (count_r != '0);
  assign rx_overrun    = overrun_r;
  assign rx_busy       = (state_r != ST_IDLE);
  assign fifo_count    = count_r;

endmodule
